// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing for the truth-table sweep controller.
// Optional expected-table compare is enabled with the EXPECT_CHECK_EN macro.
package tt_sweep_pkg;

  localparam int N_INPUTS    = 4;
  localparam int TT_WIDTH    = 16;
  localparam int ONES_WIDTH  = 5;
  localparam int TIMER_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [N_INPUTS-1:0] index_t;

  localparam index_t LAST_INDEX = index_t'(TT_WIDTH - 1);

  // The dwell timer expires when it reaches zero, so it is loaded one short.
  function automatic logic [TIMER_WIDTH-1:0] settle_load(input int settle_cycles);
    return TIMER_WIDTH'(settle_cycles - 1);
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Request/status and swept-logic signals of the sweep controller.
// EXPECT_CHECK_EN adds the reference table and the sticky mismatch flag.
interface tt_sweep_ctrl_if;
  import tt_sweep_pkg::*;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  a;
  logic                  b;
  logic                  c;
  logic                  d;
  logic                  f;
  logic [TT_WIDTH-1:0]   tt;
  logic [ONES_WIDTH-1:0] ones;

`ifdef EXPECT_CHECK_EN
  logic [TT_WIDTH-1:0]   expected;
  logic                  mismatch;

  modport master (
    output start, f, expected,
    input  a, b, c, d, busy, done, tt, ones, mismatch
  );

  modport slave (
    input  start, f, expected,
    output a, b, c, d, busy, done, tt, ones, mismatch
  );
`else
  modport master (
    output start, f,
    input  a, b, c, d, busy, done, tt, ones
  );

  modport slave (
    input  start, f,
    output a, b, c, d, busy, done, tt, ones
  );
`endif

endinterface

// File: rtl/tt_settle_timer.sv
// Down-counting dwell timer: load a count, decrement to zero, flag expiry.
module tt_settle_timer
  import tt_sweep_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_val,
  output logic                   expired
);

  logic [TIMER_WIDTH-1:0] count_reg;
  logic [TIMER_WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (count_reg != '0) begin
      count_next = count_reg - TIMER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Walks all 16 input vectors of a 4-input function and captures its truth table.
// Define EXPECT_CHECK_EN to compare each sample against a reference table.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  tt_sweep_ctrl_if.slave  sweep
);

  state_t                state_reg;
  state_t                state_next;
  index_t                index_reg;
  index_t                index_next;
  index_t                vec_reg;
  index_t                vec_next;
  logic [TT_WIDTH-1:0]   tt_reg;
  logic [TT_WIDTH-1:0]   tt_next;
  logic [ONES_WIDTH-1:0] ones_reg;
  logic [ONES_WIDTH-1:0] ones_next;
  logic                  busy_reg;
  logic                  busy_next;
  logic                  done_reg;
  logic                  done_next;
  logic                  timer_load;
  logic                  timer_expired;
  logic                  clear_tt;
  logic                  capture;

  tt_settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (settle_load(SETTLE_CYCLES)),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // done and busy are registered, so they change one cycle after DONE is entered.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    vec_next   = vec_reg;
    ones_next  = ones_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    timer_load = 1'b0;
    clear_tt   = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        vec_next = '0;
        if (sweep.start) begin
          state_next = DRIVE;
          index_next = '0;
          ones_next  = '0;
          busy_next  = 1'b1;
          timer_load = 1'b1;
          clear_tt   = 1'b1;
        end
      end
      DRIVE: begin
        if (timer_expired) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        capture   = 1'b1;
        ones_next = ones_reg + ONES_WIDTH'(sweep.f);
        if (index_reg == LAST_INDEX) begin
          state_next = DONE;
          vec_next   = '0;
        end else begin
          state_next = DRIVE;
          index_next = index_reg + index_t'(1);
          vec_next   = index_reg + index_t'(1);
          timer_load = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        vec_next   = '0;
        done_next  = 1'b1;
        busy_next  = 1'b0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < TT_WIDTH; gi++) begin : g_tt_bit
      always_comb begin
        tt_next[gi] = tt_reg[gi];
        if (clear_tt) begin
          tt_next[gi] = 1'b0;
        end else if (capture && (index_reg == index_t'(gi))) begin
          tt_next[gi] = sweep.f;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_reg <= '0;
      vec_reg   <= '0;
      tt_reg    <= '0;
      ones_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      index_reg <= index_next;
      vec_reg   <= vec_next;
      tt_reg    <= tt_next;
      ones_reg  <= ones_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

`ifdef EXPECT_CHECK_EN
  logic mismatch_reg;
  logic mismatch_next;

  always_comb begin
    mismatch_next = mismatch_reg;
    if ((state_reg == IDLE) && sweep.start) begin
      mismatch_next = 1'b0;
    end else if (capture && (sweep.f != sweep.expected[index_reg])) begin
      mismatch_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_reg <= 1'b0;
    end else begin
      mismatch_reg <= mismatch_next;
    end
  end

  assign sweep.mismatch = mismatch_reg;
`endif

  assign sweep.a    = vec_reg[3];
  assign sweep.b    = vec_reg[2];
  assign sweep.c    = vec_reg[1];
  assign sweep.d    = vec_reg[0];
  assign sweep.busy = busy_reg;
  assign sweep.done = done_reg;
  assign sweep.tt   = tt_reg;
  assign sweep.ones = ones_reg;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench: two controllers (SETTLE_CYCLES 2 and 1) sweeping a modelled function.
module tb_tt_sweep_ctrl;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  ones;
    int          lat;
    logic        mism;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_req;
  logic        sel;
  int          mode;
  logic [15:0] exp_ref;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  tt_sweep_ctrl_if if0();
  tt_sweep_ctrl_if if1();

  tt_sweep_ctrl #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .sweep(if0));
  tt_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .sweep(if1));

  // Function under sweep: 0 = parity, 1 = 4-input AND, otherwise tied 0.
  function automatic logic fmodel(input int m, input logic [3:0] v);
    case (m)
      0:       return ^v;
      1:       return &v;
      default: return 1'b0;
    endcase
  endfunction

  assign if0.start = start_req & ~sel;
  assign if1.start = start_req & sel;
  assign if0.f     = fmodel(mode, {if0.a, if0.b, if0.c, if0.d});
  assign if1.f     = fmodel(mode, {if1.a, if1.b, if1.c, if1.d});

  logic        cur_busy;
  logic        cur_done;
  logic [3:0]  cur_vec;
  logic [15:0] cur_tt;
  logic [4:0]  cur_ones;

  assign cur_busy = sel ? if1.busy : if0.busy;
  assign cur_done = sel ? if1.done : if0.done;
  assign cur_vec  = sel ? {if1.a, if1.b, if1.c, if1.d} : {if0.a, if0.b, if0.c, if0.d};
  assign cur_tt   = sel ? if1.tt : if0.tt;
  assign cur_ones = sel ? if1.ones : if0.ones;

`ifdef EXPECT_CHECK_EN
  logic cur_mism;
  assign if0.expected = exp_ref;
  assign if1.expected = exp_ref;
  assign cur_mism     = sel ? if1.mismatch : if0.mismatch;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      vectors++;
      if (cur_busy !== 1'b0 || cur_done !== 1'b0 || cur_vec !== 4'h0 ||
          cur_tt !== 16'h0000 || cur_ones !== 5'd0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: busy=%b done=%b abcd=%h tt=%h ones=%0d, want 0 0 0 0000 0",
                 k, cur_busy, cur_done, cur_vec, cur_tt, cur_ones);
      end
    end
    sel = 1'b0;
  endtask

  // Full sweep with scoreboard; restart_at re-pulses start at that cycle of the sweep.
  task automatic run_sweep(input logic use1, input logic [15:0] exp_tt, input logic [4:0] exp_ones,
                           input logic exp_mism, input int restart_at, input string name);
    exp_t       e;
    exp_t       got;
    int         s;
    int         n;
    logic       seen;
    logic [3:0] expv;
    sel    = use1;
    s      = use1 ? 1 : 2;
    e.tt   = exp_tt;
    e.ones = exp_ones;
    e.mism = exp_mism;
    e.lat  = 16 * (s + 1) + 1;
    sb.push_back(e);
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    seen = 1'b0;
    for (n = 0; n <= 200; n++) begin
      if (cur_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      expv = (n < 16 * (s + 1)) ? 4'(n / (s + 1)) : 4'h0;
      vectors++;
      if (cur_vec !== expv || cur_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_cycle%0d: abcd=%h busy=%b, want abcd=%h busy=1", name, n, cur_vec, cur_busy, expv);
      end
      if (n == restart_at) start_req = 1'b1;
      tick();
      start_req = 1'b0;
    end
    got = sb.pop_front();
    vectors++;
    if (!seen || n != got.lat) begin
      miscompares++;
      $display("FAIL %s_latency: done after %0d cycles (seen=%b), want %0d", name, n, seen, got.lat);
    end
    vectors++;
    if (cur_tt !== got.tt || cur_ones !== got.ones) begin
      miscompares++;
      $display("FAIL %s_result: tt=%h ones=%0d, want tt=%h ones=%0d", name, cur_tt, cur_ones, got.tt, got.ones);
    end
    vectors++;
    if (cur_busy !== 1'b0 || cur_vec !== 4'h0) begin
      miscompares++;
      $display("FAIL %s_at_done: busy=%b abcd=%h, want busy=0 abcd=0", name, cur_busy, cur_vec);
    end
`ifdef EXPECT_CHECK_EN
    vectors++;
    if (cur_mism !== got.mism) begin
      miscompares++;
      $display("FAIL %s_mismatch: mismatch=%b, want %b", name, cur_mism, got.mism);
    end
`endif
    tick();
    vectors++;
    if (cur_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_pulse: done=%b one cycle later, want 0", name, cur_done);
    end
    repeat (3) tick();
    vectors++;
    if (cur_tt !== got.tt || cur_ones !== got.ones || cur_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle_hold: tt=%h ones=%0d busy=%b, want tt=%h ones=%0d busy=0",
               name, cur_tt, cur_ones, cur_busy, got.tt, got.ones);
    end
    $display("sweep %s: settle=%0d tt=%h ones=%0d latency=%0d expected_mismatch=%b",
             name, s, cur_tt, cur_ones, n, got.mism);
  endtask

  task automatic test_reset_mid;
    int pulses;
    sel  = 1'b0;
    mode = 0;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (cur_busy !== 1'b0 || cur_done !== 1'b0 || cur_vec !== 4'h0 ||
        cur_tt !== 16'h0000 || cur_ones !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b abcd=%h tt=%h ones=%0d, want all 0",
               cur_busy, cur_done, cur_vec, cur_tt, cur_ones);
    end
    tick();
    rst = 1'b0;
    pulses = 0;
    repeat (60) begin
      tick();
      if (cur_done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0 || cur_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abandon: done pulses=%0d busy=%b, want 0 pulses busy=0", pulses, cur_busy);
    end
    $display("sweep reset_mid: abandoned at cycle 20, done pulses=%0d", pulses);
    run_sweep(1'b0, 16'h6996, 5'd8, 1'b0, -1, "after_reset");
  endtask

  task automatic test_parity;
    mode = 0;
    run_sweep(1'b0, 16'h6996, 5'd8, 1'b0, -1, "parity");
  endtask

  task automatic test_and_zero;
    mode = 1;
    run_sweep(1'b0, 16'h8000, 5'd1, 1'b1, -1, "and4");
    mode = 2;
    run_sweep(1'b0, 16'h0000, 5'd0, 1'b1, -1, "zero");
  endtask

  task automatic test_restart;
    mode = 0;
    run_sweep(1'b0, 16'h6996, 5'd8, 1'b0, 10, "restart");
  endtask

  task automatic test_settle1;
    mode = 0;
    run_sweep(1'b1, 16'h6996, 5'd8, 1'b0, -1, "settle1_parity");
    mode = 1;
    run_sweep(1'b1, 16'h8000, 5'd1, 1'b1, -1, "settle1_and4");
  endtask

  task automatic test_back_to_back;
    mode = 2;
    run_sweep(1'b0, 16'h0000, 5'd0, 1'b1, -1, "b2b_zero");
    mode = 0;
    run_sweep(1'b0, 16'h6996, 5'd8, 1'b0, -1, "b2b_parity");
  endtask

  initial begin
    rst       = 1'b1;
    start_req = 1'b0;
    sel       = 1'b0;
    mode      = 0;
    exp_ref   = 16'h6996;
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_parity();
    test_and_zero();
    test_restart();
    test_reset_mid();
    test_settle1();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, 2, cycles each input vector is held before f is sampled (legal 1..15).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  sweep request, sampled only in IDLE.
REQ-005 SHALL have port: a, b, c, d  output  1 each  drive vector to the 4-input combinational function under sweep.
REQ-006 SHALL have port: f  input  1  function output returned from the swept logic.
REQ-007 SHALL have port: busy  output  1  high from start acceptance until done.
REQ-008 SHALL have port: done  output  1  single-cycle pulse at sweep completion.
REQ-009 SHALL have port: tt  output  16  captured truth table, bit i = f for vector i.
REQ-010 SHALL have port: ones  output  5  count of 1s in tt (0..16).
REQ-011 SHALL, when EXPECT_CHECK_EN is defined, have ports: expected  input  16  reference table; mismatch  output  1  sticky compare flag.

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-013 SHALL in IDLE, on start=1, clear tt, ones and a 4-bit vector index to 0, assert busy and enter DRIVE next cycle.
REQ-014 SHALL map vector index i to a=i[3], b=i[2], c=i[1], d=i[0]; a..d registered, stable for the whole DRIVE+SAMPLE interval.
REQ-015 SHALL stay in DRIVE exactly SETTLE_CYCLES cycles, then enter SAMPLE for exactly one cycle.
REQ-016 SHALL in SAMPLE write f into tt[i] and add f to ones.
REQ-017 SHALL from SAMPLE go to DRIVE with i+1 if i<15; go to DONE if i=15 (no wrap of i).
REQ-018 SHALL in DONE pulse done=1 for one cycle, deassert busy the same cycle, return to IDLE.
REQ-019 SHALL yield start-acceptance-edge to done-high latency of 16*(SETTLE_CYCLES+1)+1 cycles (49 at default).
REQ-020 SHALL ignore start while busy or in DONE; no restart, no queuing.
REQ-021 SHALL hold tt and ones unchanged in IDLE until the next accepted start.
REQ-022 SHALL drive a..d = 0 in IDLE and DONE.

Reset
REQ-023 SHALL on rst=1, regardless of state, immediately force IDLE, a..d=0, busy=0, done=0, tt=16'h0000, ones=0, index=0, mismatch=0.
REQ-024 SHALL abandon a sweep on reset mid-operation with no done pulse; next sweep requires a fresh start.

Configuration
REQ-025 SHALL, with EXPECT_CHECK_EN defined, set mismatch in SAMPLE when f != expected[i], hold it until next start or reset, valid at done.
REQ-026 SHALL, without EXPECT_CHECK_EN, omit expected/mismatch ports and compare logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL take state encoding enum, N_INPUTS=4 and TT_WIDTH=16 from shared package tt_sweep_pkg.
REQ-028 SHALL implement the DRIVE dwell counter as sub-module tt_settle_timer (load, count-down, expire flag).

Verification
REQ-029 SHALL cover: f=a^b^c^d, start pulse -> done after 49 cycles, tt=16'h6996, ones=8.
REQ-030 SHALL cover: f=a&b&c&d -> tt=16'h8000, ones=1; f tied 0 -> tt=16'h0000, ones=0.
REQ-031 SHALL cover: start re-asserted at cycle 10 of a sweep -> ignored, done still at cycle 49, single done pulse.
REQ-032 SHALL cover: rst asserted at cycle 20 -> busy=0, tt=0, a..d=0 same cycle; no done; new start sweeps fully.
REQ-033 SHALL cover (EXPECT_CHECK_EN): expected=16'h6996 with parity f -> mismatch=0; with f tied 0 -> mismatch=1 at done.
REQ-034 SHALL cover: SETTLE_CYCLES=1 -> done after 33 cycles; a..d each stable exactly 2 cycles per vector.
